// File: rtl/phase_sequencer.sv
// Six-phase select sequencer driving the 3-to-6 one-hot decoder stage.
// Optional build macro PHASE_SEQ_REVERSE_EN adds the dir input for reverse stepping.
module phase_sequencer #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] nsteps,
`ifdef PHASE_SEQ_REVERSE_EN
  input  logic             dir,
`endif
  output logic [2:0]       sel,
  output logic             blank,
  output logic             step,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  logic [DIV_W-1:0] presc;
  logic [DIV_W-1:0] div_q;
  logic [CNT_W-1:0] nsteps_q;
  logic [CNT_W-1:0] remaining;

  logic       tick;
  logic       last;
  logic [2:0] sel_nxt;

  assign tick = (presc == div_q);
  // Bounded run whose final phase has just expired; continuous runs never end here.
  assign last = (nsteps_q != '0) && (remaining == CNT_W'(1));

`ifdef PHASE_SEQ_REVERSE_EN
  assign sel_nxt = dir ? ((sel == 3'd0) ? 3'd5 : sel - 3'd1)
                       : ((sel == 3'd5) ? 3'd0 : sel + 3'd1);
`else
  assign sel_nxt = (sel == 3'd5) ? 3'd0 : sel + 3'd1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= 3'd0;
      blank     <= 1'b1;
      step      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      presc     <= '0;
      remaining <= '0;
      div_q     <= '0;
      nsteps_q  <= '0;
    end else begin
      step <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          sel   <= 3'd0;
          blank <= 1'b1;
          busy  <= 1'b0;
          if (start && !stop) begin
            state     <= RUN;
            div_q     <= div;
            nsteps_q  <= nsteps;
            remaining <= nsteps;
            presc     <= '0;
            blank     <= 1'b0;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            sel   <= 3'd0;
            blank <= 1'b1;
            busy  <= 1'b0;
          end else if (tick && last) begin
            state <= IDLE;
            sel   <= 3'd0;
            blank <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (tick) begin
            presc <= '0;
            sel   <= sel_nxt;
            step  <= 1'b1;
            if (nsteps_q != '0) remaining <= remaining - CNT_W'(1);
          end else begin
            presc <= presc + DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
